// File: rtl/fir_result_fifo_if.sv
// Result stream bundle between FIR_top, the result FIFO and its consumer.
// master = filter/consumer side, slave = FIFO side.
interface fir_result_fifo_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
);
    logic [WIDTH-1:0]    in_data;
    logic                in_valid;
    logic [WIDTH-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
    logic [DEPTH_LOG2:0] level;
    logic                warm;
    logic                overflow;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, level, warm, overflow
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, level, warm, overflow
    );
endinterface

// File: rtl/fir_result_fifo.sv
// Show-ahead circular FIFO behind FIR_top: drops the first WARMUP results, then buffers.
// Optional FIFO_OVF_COUNT_EN adds a saturating 16-bit dropped-result counter port.
module fir_result_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int WARMUP     = 440
) (
    input  logic             clk,
    input  logic             rst,
    fir_result_fifo_if.slave bus
`ifdef FIFO_OVF_COUNT_EN
   ,output logic [15:0]      ovf_count
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam int CW    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_XOR = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] PTR_ONE  = 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic [AW-1:0]       wr_addr, rd_addr;
    logic [CW-1:0]       wu_cnt;
    logic                warm_q, ovf_q;
    logic                empty, full, push, pop, drop;

    generate
        if (DEPTH_LOG2 > 0) begin : g_addr
            assign wr_addr = wr_ptr[AW-1:0];
            assign rd_addr = rd_ptr[AW-1:0];
        end else begin : g_addr_single
            assign wr_addr = '0;
            assign rd_addr = '0;
        end
    endgenerate

    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr ^ rd_ptr) == FULL_XOR);
    assign pop   = !empty && bus.out_ready;
    assign push  = bus.in_valid && warm_q && (!full || pop);
    assign drop  = bus.in_valid && warm_q && full && !pop;

    // Memory is never reset, so gate the head with empty to present 0 after reset.
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_addr];
    assign bus.level     = wr_ptr - rd_ptr;
    assign bus.warm      = warm_q;
    assign bus.overflow  = ovf_q;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_addr] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (drop)
                ovf_q <= 1'b1;
        end
    end

    // The sample that brings the count to WARMUP is itself discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wu_cnt <= '0;
            warm_q <= (WARMUP == 0);
        end else if (!warm_q && bus.in_valid) begin
            wu_cnt <= wu_cnt + CW'(1);
            if (wu_cnt == CW'(WARMUP - 1))
                warm_q <= 1'b1;
        end
    end

`ifdef FIFO_OVF_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_count <= '0;
        else if (drop && ovf_count != 16'hFFFF)
            ovf_count <= ovf_count + 16'd1;
    end
`endif
endmodule

// File: doc/fir_result_fifo.md
Name: fir_result_fifo

Overview:
- Sits directly downstream of the FIR_top estimation filter.
- Captures its out/valid result stream, discards the start-up transient, and buffers results in a small circular FIFO.
- Presents results to the consumer (result sink, decimator or host readout) over a valid/ready handshake.
- Flags overflow when the consumer stalls longer than the buffer can absorb.

Parameters:
- WIDTH, 32, bit width of one filter result (matches the FIR output width).
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2^DEPTH_LOG2 entries, minimum 1.
- WARMUP, 440, number of initial valid results to discard (nominally Lookahead+Lookback); 0 disables discard.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  WIDTH  filter result from FIR_top out
- in_valid  in  1  FIR_top valid; one result per asserted cycle
- out_data  out  WIDTH  head-of-FIFO result
- out_valid  out  1  head entry present
- out_ready  in  1  consumer accepts head this cycle
- level  out  DEPTH_LOG2+1  current number of stored entries
- warm  out  1  high once WARMUP results have been discarded
- overflow  out  1  sticky: a post-warm-up result was dropped

Behaviour:
- Reset (async assert, sync release): write/read pointers = 0, level = 0, out_valid = 0, out_data = 0, warm = (WARMUP==0), overflow = 0, warm-up counter = 0. Reset mid-operation discards all stored entries and restarts warm-up.
- Warm-up counter:
  - ceil(log2(WARMUP+1)) bits wide.
  - Increments on each in_valid while warm=0.
  - When it reaches WARMUP-1 with in_valid, warm goes high at the next edge; that final sample is also discarded.
  - Discarded samples never touch the FIFO or overflow.
- Pointers are DEPTH_LOG2+1 bits.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and lower bits equal.
  - Natural binary wrap-around; no reset on wrap.
- push = in_valid & warm & (!full | pop); pop = out_valid & out_ready.
- Show-ahead output:
  - out_data = mem[rd_ptr low bits]; out_valid = !empty.
  - out_data holds its value while out_valid=1 and out_ready=0.
- Latency:
  - A result accepted at edge t appears on out_valid/out_data after edge t (readable in cycle t+1) when the FIFO was empty.
  - No combinational path from in_valid to out_valid.
- Simultaneous push & pop:
  - Allowed at any level, including full (write into freed slot) and empty with out_valid=0 (pop is impossible then; push only).
  - level unchanged when both occur.
- level: +1 on push only, -1 on pop only; never exceeds 2^DEPTH_LOG2.
- Overflow:
  - in_valid & warm & full & !pop → sample dropped, FIFO contents untouched, overflow set at next edge.
  - overflow stays set until reset.
- out_ready while empty: ignored, no pointer movement.
- Memory is not reset; only pointers are. out_data while out_valid=0 is don't-care except immediately after reset (0).

Optional Feature:
- Macro: FIFO_OVF_COUNT_EN.
- With it defined:
  - Adds output port ovf_count [15:0].
  - Counts every dropped post-warm-up result.
  - Saturates at 16'hFFFF; reset to 0 by rst.
- Without it: port absent; only the sticky overflow flag exists.

Test Plan:
- Warm-up discard: WARMUP=4, DEPTH_LOG2=2, in_valid every cycle with in_data=0..9, out_ready=1 → warm high after 4th sample; out_data sequence 4,5,6,...,9, each one cycle after its input; level ≤1.
- Fill to full: WARMUP=0, out_ready=0, push values 1..5 → level=4, out_data=1, 5th dropped, overflow=1 (ovf_count=1 with FIFO_OVF_COUNT_EN); then out_ready=1 drains 1,2,3,4, out_valid=0, level=0.
- Full with simultaneous push/pop: FIFO full of 10..13, in_data=14, in_valid=1, out_ready=1 → overflow stays 0, level stays 4, drain yields 11,12,13,14.
- Pointer wrap: DEPTH_LOG2=2, 100 random push/pop cycles against a scoreboard queue → output order and data match exactly; level equals scoreboard size every cycle.
- Backpressure stability: out_ready=0 for 7 cycles with out_valid=1 → out_data constant, level only increases.
- Async reset mid-stream: rst pulse between edges while level=3 and overflow=1 → immediately out_valid=0, level=0, overflow=0, warm=0 (WARMUP=4); next 4 inputs discarded again.
